// File: rtl/seg7_frame_decoder.sv
// Samples a scanned active-low 7-segment bus and rebuilds a DIGITS-wide BCD frame.
// Optional build macro FRAME_CHANGE_ONLY_EN suppresses frames equal to the current bcd_out.
module seg7_frame_decoder #(
    parameter int DIGITS     = 3,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  frame_vld,
    output logic                  digit_err,
    output logic                  timeout
);

    localparam int CNT_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYC - 1);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e                      state;
    logic [6:0]                  seg_q, seg_d;
    logic [DIGITS-1:0]           sel_q, sel_d;
    logic [CNT_W-1:0]            stab_cnt;
    logic [DIGITS-1:0]           seen;
    logic [DIGITS-1:0][3:0]      work;
    logic [TIMEOUT_W-1:0]        tmo_cnt;
    logic                        same;
    logic                        capture;
    logic [IDX_W-1:0]            idx;
    logic [4:0]                  dec;
`ifdef FRAME_CHANGE_ONLY_EN
    logic                        emitted;
`endif

    // Returns {err, nibble}; blank (all segments dark) decodes to F.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b1111111: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        same    = $onehot(~sel_q) && (seg_q == seg_d) && (sel_q == sel_d);
        capture = same && (stab_cnt == CNT_CAP);
        dec     = decode(seg_q);
        idx     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!sel_q[i]) idx = IDX_W'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q    <= '1;
            sel_q    <= '1;
            seg_d    <= '1;
            sel_d    <= '1;
            stab_cnt <= '0;
        end else begin
            seg_q <= seg;
            sel_q <= dig_sel;
            seg_d <= seg_q;
            sel_d <= sel_q;
            if (!same)                  stab_cnt <= '0;
            else if (stab_cnt != CNT_SAT) stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // NOTE: the digit store is only DIGITS nibbles of flops, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            seen      <= '0;
            work      <= '0;
            tmo_cnt   <= '0;
            bcd_out   <= '0;
            frame_vld <= 1'b0;
            digit_err <= 1'b0;
            timeout   <= 1'b0;
`ifdef FRAME_CHANGE_ONLY_EN
            emitted   <= 1'b0;
`endif
        end else begin
            frame_vld <= 1'b0;
            digit_err <= 1'b0;
            timeout   <= 1'b0;
            if (capture) begin
                work[idx] <= dec[3:0];
                seen[idx] <= 1'b1;
                digit_err <= dec[4];
            end
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (capture) state <= COLLECT;
                end
                COLLECT: begin
                    if (&seen) begin
`ifdef FRAME_CHANGE_ONLY_EN
                        if (!emitted || (work != bcd_out)) begin
                            bcd_out   <= work;
                            frame_vld <= 1'b1;
                            emitted   <= 1'b1;
                        end
`else
                        bcd_out   <= work;
                        frame_vld <= 1'b1;
`endif
                        seen    <= '0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else if (capture) begin
                        // A capture in the expiry cycle keeps the frame alive.
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == '1) begin
                        timeout <= 1'b1;
                        seen    <= '0;
                        work    <= '0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: stimulus pushes expected events, a monitor pops them.
module tb_seg7_frame_decoder;

    localparam int DIGITS = 3;
    localparam int STABLE = 4;
    localparam int TW     = 10;
    localparam int TMAX   = (1 << TW) - 1;
`ifdef FRAME_CHANGE_ONLY_EN
    localparam bit FCO = 1'b1;
`else
    localparam bit FCO = 1'b0;
`endif

    localparam logic [6:0] P0   = 7'b1000000;
    localparam logic [6:0] P1   = 7'b1111001;
    localparam logic [6:0] P2   = 7'b0100100;
    localparam logic [6:0] P3   = 7'b0110000;
    localparam logic [6:0] P4   = 7'b0011001;
    localparam logic [6:0] P5   = 7'b0010010;
    localparam logic [6:0] P9   = 7'b0010000;
    localparam logic [6:0] PBAD = 7'b0101010;
    localparam logic [6:0] PBLK = 7'b1111111;

    typedef enum logic [1:0] {EV_NONE, EV_FRAME, EV_ERR, EV_TMO} ev_e;
    typedef struct {
        ev_e         kind;
        logic [11:0] data;
        int          due;
        int          tol;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t_app  = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;
    logic [11:0] bcd_out;
    logic        frame_vld;
    logic        digit_err;
    logic        timeout;

    seg7_frame_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE), .TIMEOUT_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .bcd_out   (bcd_out),
        .frame_vld (frame_vld),
        .digit_err (digit_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_e k, input logic [11:0] d, input int due, input int tol);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.due  = due;
        e.tol  = tol;
        sbq.push_back(e);
    endtask

    task automatic observe(input ev_e k, input logic [11:0] d);
        exp_t e;
        ev_e  ek;
        ek = (sbq.size() > 0) ? sbq[0].kind : EV_NONE;
        check(k == ek, "event_kind", int'(k), int'(ek));
        if (k == ek) begin
            e = sbq.pop_front();
            check(d == e.data, "event_data", int'(d), int'(e.data));
            check((cyc >= e.due - e.tol) && (cyc <= e.due + e.tol), "event_time", cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (digit_err) observe(EV_ERR, bcd_out);
            if (frame_vld) observe(EV_FRAME, bcd_out);
            if (timeout)   observe(EV_TMO, bcd_out);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input logic [6:0] p);
        seg     = p;
        dig_sel = ~(3'b001 << idx);
        t_app   = cyc;
    endtask

    task automatic blank();
        seg     = PBLK;
        dig_sel = 3'b111;
    endtask

    task automatic scan3(input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0,
                         input bit want_frame, input logic [11:0] frame,
                         input bit d1_bad, input logic [11:0] cur_bcd);
        apply(2, p2);
        hold(10);
        apply(1, p1);
        if (d1_bad) push(EV_ERR, cur_bcd, t_app + STABLE + 1, 0);
        hold(10);
        apply(0, p0);
        if (want_frame) push(EV_FRAME, frame, t_app + STABLE + 2, 0);
        hold(10);
        blank();
        hold(5);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sbq.size() > 0; i++) hold(1);
        check(sbq.size() == 0, name, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(bcd_out == 12'h000, {tag, "_bcd_out"}, int'(bcd_out), 0);
        check(frame_vld == 1'b0, {tag, "_frame_vld"}, int'(frame_vld), 0);
        check(digit_err == 1'b0, {tag, "_digit_err"}, int'(digit_err), 0);
        check(timeout == 1'b0, {tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tl;
        rst     = 1'b0;
        seg     = PBLK;
        dig_sel = 3'b111;
        hold(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        hold(5);

        // Scan "120" at 10 clk per digit.
        scan3(P1, P2, P0, 1'b1, 12'h120, 1'b0, 12'h000);
        drain("t1_drain", 50);

        // 3 clk dwell never reaches capture; idle well past the timeout span.
        for (int r = 0; r < 4; r++) begin
            apply(2, P1); hold(3);
            apply(1, P2); hold(3);
            apply(0, P0); hold(3);
        end
        blank();
        hold(TMAX + 50);
        drain("t2_quiet", 1);
        check(bcd_out == 12'h120, "t2_bcd_hold", int'(bcd_out), 'h120);

        // Undecodable d1 inside "3?5".
        scan3(P3, PBAD, P5, 1'b1, 12'h3E5, 1'b1, 12'h120);
        drain("t3_drain", 50);

        // Partial frame d0,d1 then no digit selected.
        apply(0, P1);
        hold(10);
        apply(1, P2);
        tl = t_app;
        push(EV_TMO, 12'h3E5, tl + STABLE + 2 + TMAX, 1);
        hold(10);
        blank();
        drain("t4_drain", TMAX + 100);
        check(bcd_out == 12'h3E5, "t4_bcd_hold", int'(bcd_out), 'h3E5);

        // "042" twice.
        scan3(P0, P4, P2, 1'b1, 12'h042, 1'b0, 12'h000);
        drain("t5a_drain", 50);
        scan3(P0, P4, P2, !FCO, 12'h042, 1'b0, 12'h000);
        hold(20);
        drain("t5b_drain", 50);
        check(bcd_out == 12'h042, "t5_bcd", int'(bcd_out), 'h042);

        // Reset mid-frame, then scan "900".
        apply(2, P9);
        hold(10);
        apply(1, P0);
        hold(10);
        rst = 1'b0;
        hold(2);
        check_reset_outputs("midreset");
        blank();
        hold(2);
        rst = 1'b1;
        hold(20);
        scan3(P9, P0, P0, 1'b1, 12'h900, 1'b0, 12'h000);
        drain("t6_drain", 50);
        hold(20);
        check(sbq.size() == 0, "final_queue", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
